// File: rtl/fpm_pkg.sv
// Shared types and helpers for the fpm_align exponent-alignment controller.
package fpm_pkg;

    localparam int unsigned ABS_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } fpm_state_e;

    // Magnitude of a sign-extended exponent difference.
    function automatic logic [ABS_W-1:0] abs_diff(input logic signed [ABS_W-1:0] d);
        return d[ABS_W-1] ? ABS_W'(-d) : ABS_W'(d);
    endfunction

    // The shift counter must be able to hold any difference below MANT_W.
    function automatic bit cnt_w_ok(input int unsigned cnt_w, input int unsigned mant_w);
        return (cnt_w < 32) && ((64'(1) << cnt_w) > 64'(mant_w));
    endfunction

endpackage

// File: rtl/fpm_align_if.sv
// Handshake/result bundle between the exponent path, fpm_align and the mantissa shifters.
interface fpm_align_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned CNT_W = 6
);
    logic             clr;
    logic             start;
    logic [EXP_W-1:0] exp_t;
    logic [EXP_W-1:0] exp_c;
    logic             shift_rdy;
    logic             shift_out;
    logic             disc_nz;
    logic             busy;
    logic             shift_t;
    logic             shift_c;
    logic             g;
    logic             wdt;
    logic             wt;
    logic             wc;
    logic             sticky;
    logic [CNT_W-1:0] cnt;
    logic             done;

    modport master (
        output clr, start, exp_t, exp_c, shift_rdy, shift_out, disc_nz,
        input  busy, shift_t, shift_c, g, wdt, wt, wc, sticky, cnt, done
    );

    modport slave (
        input  clr, start, exp_t, exp_c, shift_rdy, shift_out, disc_nz,
        output busy, shift_t, shift_c, g, wdt, wt, wc, sticky, cnt, done
    );
endinterface

// File: rtl/fpm_shcnt.sv
// Loadable down-counter for remaining alignment shifts; saturates at zero.
module fpm_shcnt #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_one_c
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt   = r_cnt;
    assign o_one_c = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/fpm_align.sv
// Exponent-alignment controller: picks the operand to denormalise and paces its right shifts.
// Optional build macro FPM_ALIGN_STICKY_EN enables sticky accumulation (otherwise sticky stays 0).
module fpm_align
    import fpm_pkg::*;
#(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 40,
    parameter int unsigned CNT_W  = 6
) (
    input  logic        clk_sys,
    input  logic        _0_f_n,
    fpm_align_if.slave  bus
);
    localparam int unsigned DIFF_W = EXP_W + 1;

`ifdef FPM_ALIGN_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    if (!cnt_w_ok(CNT_W, MANT_W) || (EXP_W >= ABS_W - 1)) begin : g_cfg_err
        $error("fpm_align: CNT_W too narrow for MANT_W or EXP_W too wide");
    end

    fpm_state_e               r_state;
    logic signed [DIFF_W-1:0] r_diff;
    logic                     r_busy;
    logic                     r_g;
    logic                     r_wdt;
    logic                     r_wt;
    logic                     r_wc;
    logic                     r_sticky;
    logic                     r_done;

    logic [ABS_W-1:0] w_ad;
    logic             w_neg;
    logic             w_big;
    logic             w_zero;
    logic             w_load;
    logic             w_en;
    logic             w_one;
    logic [CNT_W-1:0] w_cnt;

    assign w_neg  = r_diff[DIFF_W-1];
    assign w_ad   = abs_diff(ABS_W'(r_diff));
    assign w_big  = (w_ad >= ABS_W'(MANT_W));
    assign w_zero = (w_ad == '0);
    assign w_load = (r_state == CALC) && !w_big && !w_zero;
    assign w_en   = (r_state == SHIFT) && bus.shift_rdy;

    fpm_shcnt #(.CNT_W(CNT_W)) u_shcnt (
        .i_clk      (clk_sys),
        .i_rst_n    (_0_f_n),
        .i_clr      (bus.clr),
        .i_load     (w_load),
        .i_load_val (CNT_W'(w_ad)),
        .i_en       (w_en),
        .o_cnt      (w_cnt),
        .o_one_c    (w_one)
    );

    // Control FSM; result flags hold from CALC until the next start or clr.
    always_ff @(posedge clk_sys or negedge _0_f_n) begin
        if (!_0_f_n) begin
            r_state  <= IDLE;
            r_diff   <= '0;
            r_busy   <= 1'b0;
            r_g      <= 1'b0;
            r_wdt    <= 1'b0;
            r_wt     <= 1'b0;
            r_wc     <= 1'b0;
            r_sticky <= 1'b0;
            r_done   <= 1'b0;
        end else if (bus.clr) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_g      <= 1'b0;
            r_wdt    <= 1'b0;
            r_wt     <= 1'b0;
            r_wc     <= 1'b0;
            r_sticky <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_diff   <= $signed({bus.exp_t[EXP_W-1], bus.exp_t})
                                  - $signed({bus.exp_c[EXP_W-1], bus.exp_c});
                        r_busy   <= 1'b1;
                        r_g      <= 1'b0;
                        r_wdt    <= 1'b0;
                        r_wt     <= 1'b0;
                        r_wc     <= 1'b0;
                        r_sticky <= 1'b0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_wdt <= w_neg;
                    if (w_big) begin
                        r_g      <= 1'b1;
                        r_wt     <= ~w_neg;
                        r_wc     <= w_neg;
                        r_sticky <= STICKY_EN & bus.disc_nz;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else if (w_zero) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.shift_rdy) begin
                        r_sticky <= r_sticky | (STICKY_EN & bus.shift_out);
                        if (w_one) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.shift_t = (r_state == SHIFT) & r_wdt & bus.shift_rdy;
    assign bus.shift_c = (r_state == SHIFT) & ~r_wdt & bus.shift_rdy;
    assign bus.g       = r_g;
    assign bus.wdt     = r_wdt;
    assign bus.wt      = r_wt;
    assign bus.wc      = r_wc;
    assign bus.sticky  = r_sticky;
    assign bus.cnt     = w_cnt;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_fpm_align.sv
// Self-checking bench for fpm_align: directed table, abort/reset sequences, randomized ops vs a reference model.
module tb_fpm_align;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 40;
    localparam int unsigned CNT_W  = 6;

`ifdef FPM_ALIGN_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fpm_align_if #(.EXP_W(EXP_W), .CNT_W(CNT_W)) bus ();

    fpm_align #(.EXP_W(EXP_W), .MANT_W(MANT_W), .CNT_W(CNT_W)) dut (
        .clk_sys (clk),
        ._0_f_n  (rst_n),
        .bus     (bus)
    );

    logic [14:0] w_outs;
    assign w_outs = {bus.busy, bus.shift_t, bus.shift_c, bus.g, bus.wdt, bus.wt,
                     bus.wc, bus.sticky, bus.cnt, bus.done};

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One operation checked against the arithmetic model; mode 0 rdy high, 1 toggling, 2 random.
    task automatic run_op(input int et, input int ec, input int mode, input bit dnz, input int inj,
                          input string tag, output bit o_g, output bit o_wdt,
                          output int o_shifts, output int o_lat);
        int d, ad, xs, acc, done_cyc, obs_sh, obs_lat, bad_pulse, bad_cnt, bad_done, busy_c1;
        bit xg, xwdt, xst, rdy, xp;
        d    = et - ec;
        xwdt = (d < 0);
        ad   = xwdt ? -d : d;
        xg   = (ad >= int'(MANT_W));
        xs   = xg ? 0 : ad;
        xst  = 1'b0;
        acc = 0; obs_sh = 0; obs_lat = -1; bad_pulse = 0; bad_cnt = 0; bad_done = 0; busy_c1 = 0;
        done_cyc = (xs == 0) ? 2 : -1;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.exp_t = EXP_W'(et); bus.exp_c = EXP_W'(ec);
        bus.disc_nz = dnz; bus.shift_rdy = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            bus.start = (c == inj);
            if (c == inj) begin
                bus.exp_t = 8'd100; bus.exp_c = 8'd0;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 2 == 0);
                default: rdy = ($urandom_range(3) != 0);
            endcase
            bus.shift_rdy = rdy;
            bus.shift_out = 1'($urandom_range(1));
            xp = (c >= 2) && (acc < xs) && rdy;
            @(negedge clk);
            if (c == 1) busy_c1 = int'(bus.busy);
            if (bus.shift_t !== (xp & xwdt) || bus.shift_c !== (xp & ~xwdt)) bad_pulse++;
            if (bus.shift_t === 1'b1 || bus.shift_c === 1'b1) obs_sh++;
            if (c >= 2 && bus.cnt !== CNT_W'(xs - acc)) bad_cnt++;
            if (bus.done !== (c == done_cyc)) bad_done++;
            if (bus.done === 1'b1 && obs_lat < 0) obs_lat = c;
            if (xp) begin
                acc++;
                xst |= bus.shift_out;
                if (acc == xs) done_cyc = c + 1;
            end
            if (c == done_cyc) break;
        end
        chk({tag, ".busy_c1"}, busy_c1, 1);
        chk({tag, ".pulses"}, bad_pulse, 0);
        chk({tag, ".cnt"}, bad_cnt, 0);
        chk({tag, ".done_timing"}, bad_done, 0);
        chk({tag, ".g"}, bus.g, xg);
        chk({tag, ".wdt"}, bus.wdt, xwdt);
        chk({tag, ".wt"}, bus.wt, xg & ~xwdt);
        chk({tag, ".wc"}, bus.wc, xg & xwdt);
        chk({tag, ".sticky"}, bus.sticky, STICKY_EN & (xg ? dnz : xst));
        o_g = bus.g; o_wdt = bus.wdt; o_shifts = obs_sh; o_lat = obs_lat;
        @(posedge clk); #1;
        bus.shift_rdy = 1'b0;
        @(negedge clk);
        chk({tag, ".after_done"}, {bus.done, bus.busy}, 2'b00);
        chk({tag, ".hold_g"}, {bus.g, bus.wdt}, {xg, xwdt});
    endtask

    // Start a plain op with rdy high and wait (bounded) until cnt shows 4.
    task automatic reach_cnt4(input string tag);
        bit found;
        found = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.exp_t = 8'd0; bus.exp_c = 8'd10; bus.shift_rdy = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.cnt == CNT_W'(4)) found = 1'b1;
        end
        chk({tag, ".reach_cnt4"}, found, 1);
    endtask

    task automatic no_done_for(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0) seen++;
        end
        chk({tag, ".no_done"}, seen, 0);
    endtask

    typedef struct {
        int et;
        int ec;
        int mode;
        bit dnz;
        int inj;
        bit x_g;
        bit x_wdt;
        int x_shifts;
        int x_lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        bit og, ow;
        int osh, olat, et, ec;
        vecs[0]  = '{5, 2, 0, 1'b0, 0, 1'b0, 1'b0, 3, 5};
        vecs[1]  = '{-3, 4, 1, 1'b0, 0, 1'b0, 1'b1, 7, 15};
        vecs[2]  = '{60, 10, 0, 1'b1, 0, 1'b1, 1'b0, 0, 2};
        vecs[3]  = '{17, 17, 0, 1'b1, 0, 1'b0, 1'b0, 0, 2};
        vecs[4]  = '{0, 39, 0, 1'b0, 0, 1'b0, 1'b1, 39, 41};
        vecs[5]  = '{40, 0, 0, 1'b1, 0, 1'b1, 1'b0, 0, 2};
        vecs[6]  = '{-128, 127, 0, 1'b1, 0, 1'b1, 1'b1, 0, 2};
        vecs[7]  = '{127, -128, 0, 1'b0, 0, 1'b1, 1'b0, 0, 2};
        vecs[8]  = '{-1, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1, 3};
        vecs[9]  = '{5, 0, 0, 1'b0, 3, 1'b0, 1'b0, 5, 7};
        vecs[10] = '{-20, 20, 0, 1'b1, 0, 1'b1, 1'b1, 0, 2};

        bus.clr = 1'b0; bus.start = 1'b0; bus.exp_t = '0; bus.exp_c = '0;
        bus.shift_rdy = 1'b0; bus.shift_out = 1'b0; bus.disc_nz = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", w_outs, 15'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_op(vecs[i].et, vecs[i].ec, vecs[i].mode, vecs[i].dnz, vecs[i].inj, tag,
                   og, ow, osh, olat);
            chk({tag, ".tbl_g"}, og, vecs[i].x_g);
            chk({tag, ".tbl_wdt"}, ow, vecs[i].x_wdt);
            chk({tag, ".tbl_shifts"}, osh, vecs[i].x_shifts);
            chk({tag, ".tbl_latency"}, olat, vecs[i].x_lat);
        end

        // clr while shifting with cnt=4: everything clears next cycle, no done.
        reach_cnt4("clr");
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        @(negedge clk);
        chk("clr.outs", w_outs, 15'd0);
        no_done_for("clr", 6);

        // Async reset while shifting with cnt=4: outputs clear without a clock edge.
        reach_cnt4("rst");
        rst_n = 1'b0;
        #1;
        chk("rst.outs", w_outs, 15'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        no_done_for("rst", 6);

        // start together with clr: clr wins and nothing begins.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.clr = 1'b1; bus.exp_t = 8'd0; bus.exp_c = 8'd10;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.clr = 1'b0;
        @(negedge clk);
        chk("start_clr.busy", bus.busy, 1'b0);
        @(negedge clk);
        chk("start_clr.state", {bus.wdt, bus.cnt}, 7'd0);
        no_done_for("start_clr", 4);

        for (int i = 0; i < 40; i++) begin
            ec = int'($urandom_range(255)) - 128;
            if (i % 4 == 3) begin
                et = int'($urandom_range(255)) - 128;
            end else begin
                et = ec + int'($urandom_range(90)) - 45;
                if (et > 127) et = 127;
                if (et < -128) et = -128;
            end
            run_op(et, ec, int'($urandom_range(2)), 1'($urandom_range(1)), 0,
                   $sformatf("rnd%0d", i), og, ow, osh, olat);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
